// File: rtl/pwm_mix_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_mix_scheduler: snapshots channels at PWM cycle end, accumulates one    |
// | per clock, saturates, strobes a new compare value. Option: PWM_MIX_ATTEN_EN|
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module pwm_mix_scheduler #(
    parameter int NUM_CH   = 3,
    parameter int SAMPLE_W = 9,
    parameter int OUT_W    = 9
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_CH*SAMPLE_W-1:0]   i_ch_sample,
    input  logic [NUM_CH-1:0]            i_ch_mute,
    input  logic [2*NUM_CH-1:0]          i_ch_atten,
    input  logic                         i_cycle_end,
    output logic [OUT_W-1:0]             o_compare,
    output logic                         o_compare_valid,
    output logic                         o_busy,
    output logic                         o_clip,
    output logic                         o_overrun
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SAT   = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'((64'd1 << OUT_W) - 64'd1);

    logic [1:0]                   state_q, state_d;
    logic                         pending_q, pending_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [OUT_W-1:0]             compare_q, compare_d;
    logic                         valid_q, valid_d;
    logic                         clip_q, clip_d;
    logic                         overrun_q, overrun_d;
    logic [NUM_CH*SAMPLE_W-1:0]   sample_q;
    logic [NUM_CH-1:0]            mute_q;
    logic                         snap_load;
    logic [SAMPLE_W-1:0]          sel_sample;

`ifdef PWM_MIX_ATTEN_EN
    logic [2*NUM_CH-1:0]          atten_q;
`else
    logic                         unused_atten;
    assign unused_atten = ^i_ch_atten;
`endif

    // Contribution of the channel currently addressed by idx_q.
    always_comb begin
        sel_sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if ((idx_q == IDX_W'(k)) && !mute_q[k]) begin
`ifdef PWM_MIX_ATTEN_EN
                sel_sample = sample_q[k*SAMPLE_W +: SAMPLE_W] >> atten_q[2*k +: 2];
`else
                sel_sample = sample_q[k*SAMPLE_W +: SAMPLE_W];
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        compare_d = compare_q;
        valid_d   = 1'b0;
        clip_d    = clip_q;
        overrun_d = overrun_q;
        snap_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_cycle_end) begin
                    snap_load = 1'b1;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + ACC_W'(sel_sample);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_SAT;
                end
                if (i_cycle_end) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
            end
            S_SAT: begin
                compare_d = (acc_q > SAT_MAX) ? OUT_W'(SAT_MAX) : acc_q[OUT_W-1:0];
                clip_d    = (acc_q > SAT_MAX);
                valid_d   = 1'b1;
                state_d   = S_IDLE;
                // Back-to-back frame: the restart serves one request; a second
                // simultaneous request has nowhere to queue and is dropped.
                if (pending_q || i_cycle_end) begin
                    snap_load = 1'b1;
                    pending_d = 1'b0;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = S_ACCUM;
                    if (pending_q && i_cycle_end) overrun_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            acc_q     <= '0;
            idx_q     <= '0;
            compare_q <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            compare_q <= compare_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sample_q <= '0;
            mute_q   <= '0;
`ifdef PWM_MIX_ATTEN_EN
            atten_q  <= '0;
`endif
        end else if (snap_load) begin
            sample_q <= i_ch_sample;
            mute_q   <= i_ch_mute;
`ifdef PWM_MIX_ATTEN_EN
            atten_q  <= i_ch_atten;
`endif
        end
    end

    assign o_compare       = compare_q;
    assign o_compare_valid = valid_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_clip          = clip_q;
    assign o_overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_mix_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_mix_scheduler: vector table, hand sequences and random frames      |
// | checked against an arithmetic model of the mixer.                          |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_pwm_mix_scheduler;

`ifdef PWM_MIX_ATTEN_EN
    localparam bit ATTEN_ON = 1'b1;
`else
    localparam bit ATTEN_ON = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [26:0] i_ch_sample = '0;
    logic [2:0]  i_ch_mute = '0;
    logic [5:0]  i_ch_atten = '0;
    logic        i_cycle_end = 1'b0;
    logic [8:0]  o_compare;
    logic        o_compare_valid;
    logic        o_busy;
    logic        o_clip;
    logic        o_overrun;

    pwm_mix_scheduler #(.NUM_CH(3), .SAMPLE_W(9), .OUT_W(9)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ch_sample(i_ch_sample),
        .i_ch_mute(i_ch_mute), .i_ch_atten(i_ch_atten), .i_cycle_end(i_cycle_end),
        .o_compare(o_compare), .o_compare_valid(o_compare_valid), .o_busy(o_busy),
        .o_clip(o_clip), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int vq[$];
    int cq[$];

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(negedge i_clk) if (o_compare_valid) begin
        vq.push_back(cyc);
        cq.push_back(int'(o_compare));
    end

    typedef struct {
        logic [8:0] s0, s1, s2;
        logic [2:0] mute;
        logic [5:0] atten;
        bit         scramble;
        logic [8:0] exp_cmp;
        logic       exp_clip;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Mixed sum from the definition: unmuted samples, optionally attenuated.
    function automatic int model_sum(input logic [26:0] smp, input logic [2:0] mute,
                                     input logic [5:0] att);
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) begin
            int v;
            v = int'(smp[k*9 +: 9]);
            if (ATTEN_ON) v = v >> att[2*k +: 2];
            if (!mute[k]) s += v;
        end
        return s;
    endfunction

    task automatic run_frame(input string nm, input logic [26:0] smp, input logic [2:0] mute,
                             input logic [5:0] att, input bit scr,
                             input logic [8:0] ec, input logic eclip);
        int lat, busy_cnt;
        bit got, busy_at_valid;
        @(posedge i_clk); #1;
        i_ch_sample = smp; i_ch_mute = mute; i_ch_atten = att; i_cycle_end = 1'b1;
        @(posedge i_clk); #1;
        i_cycle_end = 1'b0;
        if (scr) begin
            i_ch_sample = '0; i_ch_mute = '0; i_ch_atten = '0;
        end
        busy_cnt = o_busy ? 1 : 0;
        lat = 0; got = 1'b0; busy_at_valid = 1'b1;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge i_clk); #1;
            if (o_compare_valid) begin
                got = 1'b1; lat = k; busy_at_valid = o_busy;
            end else if (o_busy) busy_cnt++;
        end
        check({nm, " latency"}, lat, 4);
        check({nm, " busy cycles"}, busy_cnt, 4);
        check({nm, " busy low at valid"}, busy_at_valid, 0);
        check({nm, " compare"}, o_compare, ec);
        check({nm, " clip"}, o_clip, eclip);
        @(posedge i_clk); #1;
        check({nm, " valid single pulse"}, o_compare_valid, 0);
        check({nm, " compare held"}, o_compare, ec);
    endtask

    initial begin
        logic [26:0] smp;
        logic [2:0]  mute;
        logic [5:0]  att;
        int          s;

        tbl[0] = '{9'd100, 9'd50,  9'd30,  3'b000, 6'd0, 1'b0, 9'd180, 1'b0};
        tbl[1] = '{9'd255, 9'd255, 9'd255, 3'b000, 6'd0, 1'b0, 9'd511, 1'b1};
        tbl[2] = '{9'd10,  9'd0,   9'd0,   3'b000, 6'd0, 1'b0, 9'd10,  1'b0};
        tbl[3] = '{9'd100, 9'd200, 9'd30,  3'b010, 6'd0, 1'b1, 9'd130, 1'b0};
        tbl[4] = '{9'd511, 9'd0,   9'd0,   3'b000, 6'd0, 1'b0, 9'd511, 1'b0};
        tbl[5] = '{9'd256, 9'd255, 9'd0,   3'b000, 6'd0, 1'b0, 9'd511, 1'b0};
        tbl[6] = '{9'd256, 9'd256, 9'd0,   3'b000, 6'd0, 1'b0, 9'd511, 1'b1};
        tbl[7] = '{9'd500, 9'd500, 9'd500, 3'b111, 6'd0, 1'b0, 9'd0,   1'b0};
        tbl[8] = '{9'd400, 9'd400, 9'd400, 3'b000, 6'b11_10_01, 1'b0,
                   ATTEN_ON ? 9'd350 : 9'd511, !ATTEN_ON};

        // Reset state
        #12;
        check("reset compare", o_compare, 0);
        check("reset valid", o_compare_valid, 0);
        check("reset busy", o_busy, 0);
        check("reset clip", o_clip, 0);
        check("reset overrun", o_overrun, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), {tbl[i].s2, tbl[i].s1, tbl[i].s0},
                      tbl[i].mute, tbl[i].atten, tbl[i].scramble,
                      tbl[i].exp_cmp, tbl[i].exp_clip);
        end

        for (int i = 0; i < 30; i++) begin
            smp  = {9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                    9'($urandom_range(0, 511))};
            mute = 3'($urandom_range(0, 7));
            att  = 6'($urandom_range(0, 63));
            s    = model_sum(smp, mute, att);
            run_frame($sformatf("rand%0d", i), smp, mute, att, 1'($urandom_range(0, 1)),
                      (s > 511) ? 9'd511 : 9'(s), s > 511);
        end
        check("overrun clear after frames", o_overrun, 0);

        // Second strobe during ACCUM queues a back-to-back frame
        vq.delete(); cq.delete();
        @(posedge i_clk); #1;
        i_ch_sample = {9'd3, 9'd2, 9'd1}; i_ch_mute = '0; i_ch_atten = '0; i_cycle_end = 1'b1;
        @(posedge i_clk); #1; i_cycle_end = 1'b0;
        @(posedge i_clk); #1; i_cycle_end = 1'b1; i_ch_sample = {9'd9, 9'd8, 9'd7};
        @(posedge i_clk); #1; i_cycle_end = 1'b0;
        for (int k = 0; k < 20 && vq.size() < 2; k++) @(posedge i_clk);
        #1;
        check("pending two pulses", vq.size(), 2);
        if (vq.size() >= 2) begin
            check("pending pulse spacing", vq[1] - vq[0], 4);
            check("pending frame A", cq[0], 6);
            check("pending frame B", cq[1], 24);
        end
        check("pending no overrun", o_overrun, 0);

        // Third strobe while one is pending is dropped
        repeat (3) @(posedge i_clk);
        #1;
        i_cycle_end = 1'b1;
        @(posedge i_clk); #1; i_cycle_end = 1'b0;
        @(posedge i_clk); #1; i_cycle_end = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1; i_cycle_end = 1'b0;
        check("overrun set", o_overrun, 1);
        repeat (12) @(posedge i_clk);
        #1;
        check("overrun sticky", o_overrun, 1);
        check("overrun frames drained", o_busy, 0);

        // Asynchronous reset in the middle of a frame
        @(posedge i_clk); #1;
        i_ch_sample = {9'd200, 9'd200, 9'd200}; i_cycle_end = 1'b1;
        @(posedge i_clk); #1; i_cycle_end = 1'b0;
        @(posedge i_clk); #4;
        vq.delete(); cq.delete();
        i_rst_n = 1'b0;
        #1;
        check("midreset compare", o_compare, 0);
        check("midreset busy", o_busy, 0);
        check("midreset valid", o_compare_valid, 0);
        check("midreset clip", o_clip, 0);
        check("midreset overrun", o_overrun, 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (6) @(posedge i_clk);
        #1;
        check("aborted frame no pulse", vq.size(), 0);
        check("aborted frame compare", o_compare, 0);
        run_frame("post reset", {9'd3, 9'd2, 9'd1}, 3'b000, 6'd0, 1'b0, 9'd6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_mix_scheduler.md
Name: pwm_mix_scheduler

Overview:
Sequential mixer/scheduler feeding the PWM compare input.
- On each PWM cycle-end it snapshots all channel samples and mute bits.
- It accumulates the channels one per clock, saturates the sum, and presents a new compare value with a one-cycle valid strobe.
- It replaces the combinational mixer between the channel generators and the pwm block, so compare updates stay glitch-free and aligned to PWM period boundaries.

Parameters:
- NUM_CH, 3, number of channel inputs (2..8).
- SAMPLE_W, 9, width of each channel sample.
- OUT_W, 9, width of the compare output; the saturation ceiling is 2^OUT_W-1.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_ch_sample  input  NUM_CH*SAMPLE_W  packed channel samples; channel k is at bits [k*SAMPLE_W +: SAMPLE_W].
- i_ch_mute  input  NUM_CH  per-channel mute; 1 means the channel contributes 0.
- i_ch_atten  input  2*NUM_CH  per-channel right-shift amount 0..3; used only with the optional feature.
- i_cycle_end  input  1  one-cycle strobe from the pwm block marking the end of a PWM period.
- o_compare  output  OUT_W  registered mixed compare value.
- o_compare_valid  output  1  one-cycle strobe when o_compare is updated.
- o_busy  output  1  high while a frame is being accumulated.
- o_clip  output  1  the last frame saturated; updated each frame.
- o_overrun  output  1  sticky flag: a cycle-end strobe was dropped.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, pending=0, acc=0, idx=0, snapshot registers=0.
  - o_compare=0, o_compare_valid=0, o_busy=0, o_clip=0, o_overrun=0.
  - Reset mid-frame aborts the frame; o_compare is not updated.
- States: IDLE, ACCUM, SAT.
- IDLE:
  - On an edge with i_cycle_end=1: load the snapshot of i_ch_sample, i_ch_mute (and i_ch_atten), clear acc, set idx=0, go to ACCUM.
- ACCUM:
  - Each edge adds (mute[idx] ? 0 : sample[idx]) to acc, then increments idx.
  - After the edge that adds channel NUM_CH-1, go to SAT.
  - Accumulator width is SAMPLE_W+clog2(NUM_CH)+1 bits and must never wrap.
- SAT:
  - o_compare <= (acc > 2^OUT_W-1) ? 2^OUT_W-1 : acc[OUT_W-1:0].
  - o_clip <= (acc > 2^OUT_W-1).
  - o_compare_valid=1 for exactly the following cycle.
  - Next state is IDLE, unless pending=1 or i_cycle_end=1 on this edge. In that case take the snapshot now, clear pending and acc, set idx=0, and go to ACCUM.
- Latency: o_compare_valid is high in the cycle after edge NUM_CH+1, counting the edge that sampled i_cycle_end as edge 0. For NUM_CH=3 that is 4 cycles.
- o_busy is 1 in ACCUM and SAT, and 0 in IDLE.
- i_cycle_end while in ACCUM (or SAT with a restart not possible): set pending=1.
- i_cycle_end while pending=1 already: drop the strobe and set o_overrun=1, which stays set until reset.
- Snapshot isolation: input changes after the snapshot edge do not affect the current frame.
- o_compare holds its value between frames. The downstream pwm block samples it at its own period boundary.

Optional Feature:
- Macro: PWM_MIX_ATTEN_EN.
- Defined: each snapshotted sample is right-shifted by its 2-bit i_ch_atten field (logical shift, 0..3) before accumulation. Mute still forces 0. The attenuation is also snapshotted at frame start.
- Undefined: i_ch_atten is ignored (no logic generated), and samples are accumulated unshifted.

Test Plan:
1. Reset, then samples {100,50,30} with no mutes, then pulse i_cycle_end -> o_compare=180; o_compare_valid is a single pulse 4 cycles later; o_clip=0; o_busy is high for 4 cycles.
2. Samples {255,255,255}, cycle_end -> o_compare=511, o_clip=1. Next frame with {10,0,0} -> o_compare=10, o_clip=0.
3. Mute=3'b010 with samples {100,200,30}, cycle_end; change the samples to {0,0,0} one cycle later -> o_compare=130 (snapshot held, channel 1 muted).
4. Second cycle_end 2 cycles after the first -> pending set; the second frame starts at the SAT edge; two valid pulses exactly 4 cycles apart; o_overrun=0. A third strobe while pending -> o_overrun=1 and it remains 1.
5. Assert i_rst_n=0 during ACCUM -> all outputs 0 immediately. Release, then cycle_end with {1,2,3} -> o_compare=6.
6. With PWM_MIX_ATTEN_EN: samples {400,400,400}, atten {1,2,3} -> o_compare=200+100+50=350. Without the macro, same stimulus -> o_compare=511, o_clip=1.
